// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 device end of the external-memory link.
// Oversamples sclk/cs_n/mosi in the clk domain, decodes write (0x02) and
// read (0x03) commands with a 3-byte address, and backs data onto a byte array.
// Optional feature macro: SPI_RESP_AUTOINC_EN enables address auto-increment
// bursts; when undefined each transaction carries exactly one data byte.
module spi_mem_responder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned MEM_AW     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  wr_pulse,
    output logic                  cmd_err,
    input  logic [MEM_AW-1:0]     dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'h03);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [2:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;

    logic [DATA_WIDTH-2:0] rx_q, rx_nxt;
    logic [DATA_WIDTH-2:0] tx_q, tx_nxt;
    logic [2:0]            bit_cnt, bit_cnt_nxt;
    logic [1:0]            byte_cnt, byte_cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  is_read, is_read_nxt;
    logic                  pend, pend_nxt;
    logic                  miso_nxt, miso_oe_nxt, wr_pulse_nxt, cmd_err_nxt;
    logic                  mem_we_c;

    logic                  sclk_rise_c, sclk_fall_c, cs_hi_c, mosi_bit_c;
    logic [DATA_WIDTH-1:0] rx_shift_c;
    logic [ADDR_WIDTH-1:0] addr_shift_c;
    logic [MEM_AW-1:0]     rd_idx_c;
    logic [DATA_WIDTH-1:0] rd_byte_c;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign sclk_rise_c  = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall_c  = ~sclk_sync[1] & sclk_sync[2];
    assign cs_hi_c      = cs_sync[1];
    assign mosi_bit_c   = mosi_sync[1];
    assign rx_shift_c   = {rx_q, mosi_bit_c};
    // 24 address bits shift through; only the last ADDR_WIDTH survive
    assign addr_shift_c = ADDR_WIDTH'({addr_q, mosi_bit_c});

`ifdef SPI_RESP_AUTOINC_EN
    logic [ADDR_WIDTH-1:0] addr_inc_c;
    assign addr_inc_c = addr_q + ADDR_WIDTH'(1);
    assign rd_idx_c   = (state == S_ADDR) ? addr_shift_c[MEM_AW-1:0] : addr_inc_c[MEM_AW-1:0];
`else
    assign rd_idx_c   = addr_shift_c[MEM_AW-1:0];
`endif
    assign rd_byte_c = mem[rd_idx_c];
    assign dbg_data  = mem[dbg_addr];

    // Input synchronizers; cs_n idles high so it resets to 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; deselect overrides any coincident sclk edge
    always_comb begin
        state_nxt = state;
        if (cs_hi_c) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_CMD;
                S_CMD:   if (sclk_rise_c && bit_cnt == 3'd7)
                             state_nxt = (rx_shift_c == CMD_WRITE || rx_shift_c == CMD_READ) ? S_ADDR : S_IGNORE;
                S_ADDR:  if (sclk_rise_c && bit_cnt == 3'd7 && byte_cnt == 2'd2)
                             state_nxt = is_read ? S_RDATA : S_WDATA;
`ifdef SPI_RESP_AUTOINC_EN
                S_WDATA: state_nxt = S_WDATA;
                S_RDATA: state_nxt = S_RDATA;
`else
                S_WDATA: if (sclk_rise_c && bit_cnt == 3'd7) state_nxt = S_IGNORE;
                S_RDATA: if (sclk_fall_c && pend && bit_cnt == 3'd0) state_nxt = S_IGNORE;
`endif
                S_IGNORE: state_nxt = S_IGNORE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        rx_nxt       = rx_q;
        tx_nxt       = tx_q;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        addr_nxt     = addr_q;
        is_read_nxt  = is_read;
        pend_nxt     = pend;
        miso_nxt     = miso;
        miso_oe_nxt  = miso_oe;
        wr_pulse_nxt = 1'b0;
        cmd_err_nxt  = 1'b0;
        mem_we_c     = 1'b0;
        if (cs_hi_c || state == S_IDLE) begin
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = '0;
            pend_nxt     = 1'b0;
            miso_nxt     = 1'b0;
            miso_oe_nxt  = 1'b0;
        end else begin
            case (state)
                S_CMD: if (sclk_rise_c) begin
                    rx_nxt      = rx_shift_c[DATA_WIDTH-2:0];
                    bit_cnt_nxt = 3'(bit_cnt + 3'd1);
                    if (bit_cnt == 3'd7) begin
                        if (rx_shift_c == CMD_WRITE)     is_read_nxt = 1'b0;
                        else if (rx_shift_c == CMD_READ) is_read_nxt = 1'b1;
                        else                             cmd_err_nxt = 1'b1;
                    end
                end
                S_ADDR: if (sclk_rise_c) begin
                    addr_nxt    = addr_shift_c;
                    bit_cnt_nxt = 3'(bit_cnt + 3'd1);
                    if (bit_cnt == 3'd7) begin
                        byte_cnt_nxt = 2'(byte_cnt + 2'd1);
                        if (byte_cnt == 2'd2) begin
                            byte_cnt_nxt = '0;
                            if (is_read) begin
                                tx_nxt      = rd_byte_c[DATA_WIDTH-2:0];
                                miso_nxt    = rd_byte_c[DATA_WIDTH-1];
                                miso_oe_nxt = 1'b1;
                                pend_nxt    = 1'b0;
                            end
                        end
                    end
                end
                S_WDATA: if (sclk_rise_c) begin
                    rx_nxt      = rx_shift_c[DATA_WIDTH-2:0];
                    bit_cnt_nxt = 3'(bit_cnt + 3'd1);
                    if (bit_cnt == 3'd7) begin
                        mem_we_c     = 1'b1;
                        wr_pulse_nxt = 1'b1;
`ifdef SPI_RESP_AUTOINC_EN
                        addr_nxt     = addr_inc_c;
`endif
                    end
                end
                S_RDATA: begin
                    // a fall only advances MISO once the master has sampled a bit
                    if (sclk_rise_c) begin
                        bit_cnt_nxt = 3'(bit_cnt + 3'd1);
                        pend_nxt    = 1'b1;
                    end else if (sclk_fall_c && pend) begin
                        pend_nxt = 1'b0;
                        if (bit_cnt == 3'd0) begin
`ifdef SPI_RESP_AUTOINC_EN
                            addr_nxt = addr_inc_c;
                            tx_nxt   = rd_byte_c[DATA_WIDTH-2:0];
                            miso_nxt = rd_byte_c[DATA_WIDTH-1];
`else
                            miso_nxt    = 1'b0;
                            miso_oe_nxt = 1'b0;
`endif
                        end else begin
                            miso_nxt = tx_q[DATA_WIDTH-2];
                            tx_nxt   = {tx_q[DATA_WIDTH-3:0], 1'b0};
                        end
                    end
                end
                default: begin
                    miso_nxt    = 1'b0;
                    miso_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q     <= '0;
            tx_q     <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            addr_q   <= '0;
            is_read  <= 1'b0;
            pend     <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            wr_pulse <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            rx_q     <= rx_nxt;
            tx_q     <= tx_nxt;
            bit_cnt  <= bit_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            addr_q   <= addr_nxt;
            is_read  <= is_read_nxt;
            pend     <= pend_nxt;
            miso     <= miso_nxt;
            miso_oe  <= miso_oe_nxt;
            wr_pulse <= wr_pulse_nxt;
            cmd_err  <= cmd_err_nxt;
        end
    end

    // Backing array; deliberately not reset so contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[addr_q[MEM_AW-1:0]] <= rx_shift_c;
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: directed SPI frames; expected write/err/read
// events go into a queue that independent monitors pop and compare.
module tb_spi_mem_responder;
    localparam int HALF   = 6;
    localparam int EV_WR  = 0;
    localparam int EV_ERR = 1;
    localparam int EV_RD  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, wr_pulse, cmd_err;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_err = 0;

    spi_mem_responder dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wr_pulse(wr_pulse), .cmd_err(cmd_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected event kind", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event kind", 32'(kind), 32'(e.kind));
            if (kind != EV_ERR) check("event data", 32'(data), 32'(e.data));
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_start;
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_end;
        wait_clk(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(10);
    endtask

    task automatic spi_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] rd;
        spi_bits(cmd, 8, rd);
        spi_bits(addr[23:16], 8, rd);
        spi_bits(addr[15:8], 8, rd);
        spi_bits(addr[7:0], 8, rd);
    endtask

    // Write/command-error monitor: write data is checked on dbg_data in the pulse cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_pulse) observe(EV_WR, dbg_data);
            if (cmd_err)  observe(EV_ERR, 8'h00);
        end
    end

    // Read monitor: collects MISO on sclk rise while the data phase is driven
    initial begin : rd_mon
        logic [7:0] sh;
        int         nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) begin
                nb = 0;
            end else if (miso_oe) begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    observe(EV_RD, sh);
                    nb = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] rd;
        wait_clk(4);
        check("reset miso", 32'(miso), 0);
        check("reset miso_oe", 32'(miso_oe), 0);
        check("reset wr_pulse", 32'(wr_pulse), 0);
        check("reset cmd_err", 32'(cmd_err), 0);
        reset = 1'b0;
        wait_clk(6);

        // single write of 0x55 to address 0x000100 (index 0x00)
        dbg_addr = 8'h00;
        expect_ev(EV_WR, 8'h55);
        spi_start; spi_hdr(8'h02, 24'h000100); spi_bits(8'h55, 8, rd); spi_end;
        check("write 55 dbg", 32'(dbg_data), 32'h55);

        // overwrite with 0xAA, then read it back
        expect_ev(EV_WR, 8'hAA);
        spi_start; spi_hdr(8'h02, 24'h000100); spi_bits(8'hAA, 8, rd); spi_end;
        check("write AA dbg", 32'(dbg_data), 32'hAA);
        expect_ev(EV_RD, 8'hAA);
        spi_start; spi_hdr(8'h03, 24'h000100);
        check("read oe before data", 32'(miso_oe), 1);
        spi_bits(8'h00, 8, rd);
        check("read AA bits", 32'(rd), 32'hAA);
`ifndef SPI_RESP_AUTOINC_EN
        wait_clk(5);
        check("read oe after byte", 32'(miso_oe), 0);
`endif
        spi_end;
        check("read oe after cs", 32'(miso_oe), 0);
        check("read miso after cs", 32'(miso), 0);

        // burst at 0x0000FF crossing the index wrap
        dbg_addr = 8'hFF;
        expect_ev(EV_WR, 8'h11);
`ifdef SPI_RESP_AUTOINC_EN
        expect_ev(EV_WR, 8'h22);
`endif
        spi_start; spi_hdr(8'h02, 24'h0000FF);
        spi_bits(8'h11, 8, rd);
        dbg_addr = 8'h00;
        spi_bits(8'h22, 8, rd);
        spi_end;
        dbg_addr = 8'hFF;
        wait_clk(1);
        check("burst idx FF", 32'(dbg_data), 32'h11);
        dbg_addr = 8'h00;
        wait_clk(1);
`ifdef SPI_RESP_AUTOINC_EN
        check("burst idx 00", 32'(dbg_data), 32'h22);
`else
        check("burst idx 00", 32'(dbg_data), 32'hAA);
`endif

        // unsupported command, then ones on MOSI must not produce MISO
        expect_ev(EV_ERR, 8'h00);
        spi_start; spi_bits(8'h9F, 8, rd);
        spi_bits(8'hFF, 8, rd);
        check("bad cmd miso", 32'(rd), 0);
        spi_bits(8'h02, 8, rd);
        check("bad cmd miso 2", 32'(rd), 0);
        spi_end;

        // next frame works: read back index 0xFF
        expect_ev(EV_RD, 8'h11);
        spi_start; spi_hdr(8'h03, 24'h0000FF); spi_bits(8'h00, 8, rd); spi_end;
        check("read after err", 32'(rd), 32'h11);

        // abort a write after 5 data bits
        dbg_addr = 8'h10;
        expect_ev(EV_WR, 8'h5A);
        spi_start; spi_hdr(8'h02, 24'h000010); spi_bits(8'h5A, 8, rd); spi_end;
        spi_start; spi_hdr(8'h02, 24'h000010); spi_bits(8'hC3, 5, rd); spi_end;
        check("abort keeps byte", 32'(dbg_data), 32'h5A);

        // reset in the middle of a read
        spi_start; spi_hdr(8'h03, 24'h000010); spi_bits(8'h00, 3, rd);
        check("mid-read oe", 32'(miso_oe), 1);
        reset = 1'b1;
        #1;
        check("reset miso async", 32'(miso), 0);
        check("reset oe async", 32'(miso_oe), 0);
        wait_clk(3);
        cs_n = 1'b1;
        sclk = 1'b0;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(6);
        check("array kept on reset", 32'(dbg_data), 32'h5A);

        // normal read after reset
        expect_ev(EV_RD, 8'h5A);
        spi_start; spi_hdr(8'h03, 24'h000010); spi_bits(8'h00, 8, rd); spi_end;
        check("read after reset", 32'(rd), 32'h5A);

        wait_clk(10);
        check("pending events", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
